// File: rtl/mem_bus_arbiter.sv
// Shares the byte-wide external memory bus between instruction fetch and load/store.
// Wide accesses become byte transactions; read bytes are reassembled little-endian.
//
// state | meaning
// IDLE  | bus free, arbitrating (data requests beat fetch)
// FETCH | 4-byte instruction read, abortable by flush_in
// LOAD  | 1/2/4-byte data read
// STORE | 1/2/4-byte data write, stalls on full UART buffer for I/O addresses
module mem_bus_arbiter #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              io_buffer_full,
   input  logic              flush_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_done_out,
   output logic [31:0]       if_inst_out,
   input  logic              d_rd_req_in,
   input  logic              d_wr_req_in,
   input  logic [ADDR_W-1:0] d_addr_in,
   input  logic [31:0]       d_wdata_in,
   input  logic [2:0]        d_len_in,
   output logic              d_done_out,
   output logic [31:0]       d_rdata_out,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   output logic [1:0]        busy_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      LOAD  = 2'b10,
      STORE = 2'b11
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [2:0]        len;
   logic [2:0]        cnt;
   logic [31:0]       wbuf;
   logic [31:0]       rbuf;
   logic              wr_q;

   logic [2:0]        len_sel;
   logic [2:0]        cnt_inc;
   logic [1:0]        rd_idx;
   logic [31:0]       rbuf_nxt;
   logic              io_stall_new;
   logic              io_stall_cur;

   assign busy_out     = state;
   assign mem_wr       = wr_q & rdy_in;
   assign cnt_inc      = cnt + 3'd1;
   assign rd_idx       = cnt[1:0] - 2'd1;
   assign io_stall_new = (d_addr_in[17:16] == IO_SEL) && io_buffer_full;
   assign io_stall_cur = (base[17:16] == IO_SEL) && io_buffer_full;

   always_comb begin
      case (d_len_in)
         3'd1:    len_sel = 3'd1;
         3'd2:    len_sel = 3'd2;
         default: len_sel = 3'd4;
      endcase
   end

   // Read data lags the address by two edges, so count value c captures byte c-1.
   always_comb begin
      rbuf_nxt = rbuf;
      if (cnt != 3'd0) rbuf_nxt[{rd_idx, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= IDLE;
         base        <= '0;
         len         <= 3'd0;
         cnt         <= 3'd0;
         wbuf        <= 32'd0;
         rbuf        <= 32'd0;
         wr_q        <= 1'b0;
         mem_a       <= '0;
         mem_dout    <= 8'd0;
         if_done_out <= 1'b0;
         if_inst_out <= 32'd0;
         d_done_out  <= 1'b0;
         d_rdata_out <= 32'd0;
      end else if (rdy_in) begin
         if_done_out <= 1'b0;
         d_done_out  <= 1'b0;
         wr_q        <= 1'b0;
         case (state)
            IDLE: begin
               if (d_wr_req_in) begin
                  state <= STORE;
                  base  <= d_addr_in;
                  len   <= len_sel;
                  wbuf  <= d_wdata_in;
                  mem_a <= d_addr_in;
                  if (io_stall_new) begin
                     cnt <= 3'd0;
                  end else begin
                     mem_dout <= d_wdata_in[7:0];
                     wr_q     <= 1'b1;
                     cnt      <= 3'd1;
                  end
               end else if (d_rd_req_in) begin
                  state <= LOAD;
                  base  <= d_addr_in;
                  len   <= len_sel;
                  mem_a <= d_addr_in;
                  cnt   <= 3'd0;
                  rbuf  <= 32'd0;
               end else if (if_req_in && !flush_in) begin
                  state <= FETCH;
                  base  <= if_addr_in;
                  len   <= 3'd4;
                  mem_a <= if_addr_in;
                  cnt   <= 3'd0;
                  rbuf  <= 32'd0;
               end
            end
            FETCH, LOAD: begin
               if (state == FETCH && flush_in) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else begin
                  if (cnt_inc < len) mem_a <= base + ADDR_W'(cnt_inc);
                  rbuf <= rbuf_nxt;
                  if (cnt == len) begin
                     state <= IDLE;
                     cnt   <= 3'd0;
                     if (state == FETCH) begin
                        if_done_out <= 1'b1;
                        if_inst_out <= rbuf_nxt;
                     end else begin
                        d_done_out  <= 1'b1;
                        d_rdata_out <= rbuf_nxt;
                     end
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            STORE: begin
               if (cnt == len) begin
                  state      <= IDLE;
                  cnt        <= 3'd0;
                  d_done_out <= 1'b1;
               end else if (!io_stall_cur) begin
                  mem_a    <= base + ADDR_W'(cnt);
                  mem_dout <= wbuf[{cnt[1:0], 3'b000} +: 8];
                  wr_q     <= 1'b1;
                  cnt      <= cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a byte memory model answers reads one cycle
// after the address, and expected writes and completions are queued as requests are driven.
module tb_mem_bus_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        io_buffer_full = 1'b0;
   logic        flush_in = 1'b0;
   logic        if_req_in = 1'b0;
   logic [31:0] if_addr_in = 32'd0;
   logic        if_done_out;
   logic [31:0] if_inst_out;
   logic        d_rd_req_in = 1'b0;
   logic        d_wr_req_in = 1'b0;
   logic [31:0] d_addr_in = 32'd0;
   logic [31:0] d_wdata_in = 32'd0;
   logic [2:0]  d_len_in = 3'd4;
   logic        d_done_out;
   logic [31:0] d_rdata_out;
   logic [7:0]  mem_din = 8'd0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  busy_out;

   always #5 clk_in = ~clk_in;

   mem_bus_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .io_buffer_full(io_buffer_full), .flush_in(flush_in),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in),
      .if_done_out(if_done_out), .if_inst_out(if_inst_out),
      .d_rd_req_in(d_rd_req_in), .d_wr_req_in(d_wr_req_in),
      .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in), .d_len_in(d_len_in),
      .d_done_out(d_done_out), .d_rdata_out(d_rdata_out),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .busy_out(busy_out)
   );

   logic [7:0] mem_arr [logic [31:0]];

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return 8'h00;
   endfunction

   always @(posedge clk_in) begin
      mem_din <= mem_rd(mem_a);
      if (mem_wr) mem_arr[mem_a] = mem_dout;
   end

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   logic [31:0] exp_if [$];
   logic [32:0] exp_d  [$];
   logic [39:0] exp_wr [$];
   logic [39:0] mon_w;
   logic [31:0] mon_i;
   logic [32:0] mon_d;

   always @(negedge clk_in) begin
      if (rst_in) begin
         if (mem_wr) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("wr_spurious", {31'b0, mem_wr}, 32'd0);
            else begin
               mon_w = exp_wr.pop_front();
               chk("wr_addr", mem_a, mon_w[39:8]);
               chk("wr_data", {24'h0, mem_dout}, {24'h0, mon_w[7:0]});
            end
         end
         if (if_done_out) begin
            if (exp_if.size() == 0) chk("if_spurious", {31'b0, if_done_out}, 32'd0);
            else begin
               mon_i = exp_if.pop_front();
               chk("if_inst", if_inst_out, mon_i);
            end
         end
         if (d_done_out) begin
            if (exp_d.size() == 0) chk("d_spurious", {31'b0, d_done_out}, 32'd0);
            else begin
               mon_d = exp_d.pop_front();
               if (mon_d[32]) chk("d_rdata", d_rdata_out, mon_d[31:0]);
               else chk("st_drain", exp_wr.size(), 32'd0);
            end
         end
      end
   end

   task automatic wait_d(input int bound, output int lat);
      lat = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk_in);
         if (d_done_out) begin
            lat = i;
            d_rd_req_in = 1'b0;
            d_wr_req_in = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ld, fl;
      mem_arr[32'h100] = 8'h13; mem_arr[32'h101] = 8'h05;
      mem_arr[32'h102] = 8'h00; mem_arr[32'h103] = 8'h00;
      mem_arr[32'h40]  = 8'h34; mem_arr[32'h41]  = 8'h12;
      mem_arr[32'h200] = 8'h78; mem_arr[32'h201] = 8'h56;
      mem_arr[32'h202] = 8'h34; mem_arr[32'h203] = 8'h12;
      mem_arr[32'h300] = 8'hFF; mem_arr[32'h301] = 8'hFF;
      mem_arr[32'h302] = 8'hFF; mem_arr[32'h303] = 8'hFF;
      mem_arr[32'h400] = 8'h93; mem_arr[32'h401] = 8'h00;
      mem_arr[32'h402] = 8'h10; mem_arr[32'h403] = 8'h00;
      mem_arr[32'h500] = 8'h11; mem_arr[32'h501] = 8'h22;
      mem_arr[32'h502] = 8'h33; mem_arr[32'h503] = 8'h44;

      #2 rst_in = 1'b0;
      #10;
      chk("rst_busy",  {30'b0, busy_out}, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_wr",    {31'b0, mem_wr}, 32'd0);
      chk("rst_dout",  {24'b0, mem_dout}, 32'd0);
      chk("rst_ifd",   {31'b0, if_done_out}, 32'd0);
      chk("rst_inst",  if_inst_out, 32'd0);
      chk("rst_dd",    {31'b0, d_done_out}, 32'd0);
      chk("rst_rdata", d_rdata_out, 32'd0);
      @(negedge clk_in) rst_in = 1'b1;
      @(negedge clk_in);

      // fetch at 0x100
      exp_if.push_back(32'h0000_0513);
      if_addr_in = 32'h100;
      if_req_in  = 1'b1;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk_in);
         if (i == 1) chk("f_busy", {30'b0, busy_out}, 32'd1);
         if (i <= 4) begin
            chk("f_addr", mem_a, 32'h100 + 32'(i) - 32'd1);
            chk("f_wr", {31'b0, mem_wr}, 32'd0);
         end
         if (if_done_out) begin
            lat = i;
            if_req_in = 1'b0;
            break;
         end
      end
      chk("f_lat", lat, 32'd6);
      @(negedge clk_in);

      // 4-byte store
      exp_wr.push_back({32'h2000, 8'hEF});
      exp_wr.push_back({32'h2001, 8'hBE});
      exp_wr.push_back({32'h2002, 8'hAD});
      exp_wr.push_back({32'h2003, 8'hDE});
      exp_d.push_back({1'b0, 32'h0});
      wr_cnt = 0;
      d_addr_in = 32'h2000; d_wdata_in = 32'hDEAD_BEEF; d_len_in = 3'd4;
      d_wr_req_in = 1'b1;
      wait_d(20, lat);
      chk("st_lat", lat, 32'd5);
      chk("st_wcnt", wr_cnt, 32'd4);
      @(negedge clk_in);

      // load and fetch raised together: load wins, fetch follows after one idle cycle
      exp_d.push_back({1'b1, 32'h0000_1234});
      exp_if.push_back(32'h1234_5678);
      d_addr_in = 32'h40; d_len_in = 3'd2; d_rd_req_in = 1'b1;
      if_addr_in = 32'h200; if_req_in = 1'b1;
      ld = -1; fl = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk_in);
         if (i == 1) chk("arb_busy_ld", {30'b0, busy_out}, 32'd2);
         if (i == 4) chk("arb_idle", {30'b0, busy_out}, 32'd0);
         if (i == 5) chk("arb_busy_f", {30'b0, busy_out}, 32'd1);
         if (d_done_out) begin ld = i; d_rd_req_in = 1'b0; end
         if (if_done_out) begin fl = i; if_req_in = 1'b0; break; end
      end
      chk("arb_ld_lat", ld, 32'd4);
      chk("arb_f_lat", fl, 32'd10);
      @(negedge clk_in);

      // flush two cycles into a fetch, then fetch the branch target
      exp_if.push_back(32'h0010_0093);
      if_addr_in = 32'h300; if_req_in = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_in);
         if (i == 2) flush_in = 1'b1;
         if (i == 3) begin
            chk("fl_busy", {30'b0, busy_out}, 32'd0);
            chk("fl_wr", {31'b0, mem_wr}, 32'd0);
            flush_in = 1'b0;
            if_addr_in = 32'h400;
         end
         if (if_done_out) begin
            lat = i;
            if_req_in = 1'b0;
            break;
         end
      end
      chk("fl_lat", lat, 32'd9);
      @(negedge clk_in);

      // I/O store held off by a full UART buffer
      exp_wr.push_back({32'h30000, 8'hA5});
      exp_d.push_back({1'b0, 32'h0});
      wr_cnt = 0;
      d_addr_in = 32'h30000; d_wdata_in = 32'h0000_00A5; d_len_in = 3'd1;
      io_buffer_full = 1'b1;
      d_wr_req_in = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_in);
         if (i <= 3) chk("io_hold", {31'b0, mem_wr}, 32'd0);
         if (i == 3) io_buffer_full = 1'b0;
         if (i == 4) chk("io_wr", {31'b0, mem_wr}, 32'd1);
         if (d_done_out) begin
            lat = i;
            d_wr_req_in = 1'b0;
            break;
         end
      end
      chk("io_lat", lat, 32'd5);
      chk("io_wcnt", wr_cnt, 32'd1);
      @(negedge clk_in);

      // request waits while rdy_in is low; 1-byte load once released
      rdy_in = 1'b0;
      exp_d.push_back({1'b1, 32'h0000_0011});
      d_addr_in = 32'h500; d_len_in = 3'd1; d_rd_req_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk("rdy_busy", {30'b0, busy_out}, 32'd0);
      rdy_in = 1'b1;
      wait_d(20, lat);
      chk("len1_lat", lat, 32'd3);
      @(negedge clk_in);

      // unsupported length behaves as 4 bytes
      exp_d.push_back({1'b1, 32'h4433_2211});
      d_len_in = 3'd3; d_rd_req_in = 1'b1;
      wait_d(20, lat);
      chk("len3_lat", lat, 32'd6);
      @(negedge clk_in);

      // asynchronous reset in the middle of a load
      d_addr_in = 32'h40; d_len_in = 3'd2; d_rd_req_in = 1'b1;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("mr_busy",  {30'b0, busy_out}, 32'd0);
      chk("mr_mem_a", mem_a, 32'd0);
      chk("mr_rdata", d_rdata_out, 32'd0);
      chk("mr_inst",  if_inst_out, 32'd0);
      d_rd_req_in = 1'b0;
      @(negedge clk_in) rst_in = 1'b1;
      @(negedge clk_in);
      exp_d.push_back({1'b1, 32'h0000_1234});
      d_rd_req_in = 1'b1;
      wait_d(20, lat);
      chk("mr_lat", lat, 32'd4);
      @(negedge clk_in);

      chk("q_if", exp_if.size(), 32'd0);
      chk("q_d",  exp_d.size(),  32'd0);
      chk("q_wr", exp_wr.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
